// File: rtl/wb_buffer.sv
// wb_buffer: circular writeback buffer between execute and the regfile write port.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_addr/in_data accept results;
// hold stalls draining; wp_enable/wp_addr/wp_data drive the regfile write port;
// byp_addr/byp_hit/byp_data look up the youngest pending result; count/empty report occupancy.
module wb_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REG = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(NUM_REG),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AW-1:0]         in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  hold,
  output logic                  wp_enable,
  output logic [AW-1:0]         wp_addr,
  output logic [DATA_WIDTH-1:0] wp_data,
  input  logic [AW-1:0]         byp_addr,
  output logic                  byp_hit,
  output logic [DATA_WIDTH-1:0] byp_data,
  output logic [CW-1:0]         count,
  output logic                  empty
);
  logic [DEPTH-1:0]      vld;
  logic [AW-1:0]         addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         head, tail, idx;
  logic                  live, push, pop;
  assign empty     = count == '0;
  assign pop       = !empty && !hold;
  // live keeps in_ready low during reset and rises on the first edge after release
  assign in_ready  = live && (count < CW'(DEPTH) || pop);
  assign push      = in_valid && in_ready;
  assign wp_enable = pop;
  assign wp_addr   = pop ? addr_q[head] : '0;
  assign wp_data   = pop ? data_q[head] : '0;
  // walk oldest to youngest so the last match wins
  always_comb begin
    byp_hit = 1'b0;
    byp_data = '0;
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (vld[idx] && addr_q[idx] == byp_addr) begin
        byp_hit = 1'b1;
        byp_data = data_q[idx];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        head <= head + 1'b1;
        vld[head] <= 1'b0;
      end
      // after the pop clear so a full-buffer push into the slot being drained keeps it valid
      if (push) begin
        tail <= tail + 1'b1;
        vld[tail] <= 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
endmodule

// File: tb/tb_wb_buffer.sv
// tb_wb_buffer: self-checking bench for wb_buffer with a reference queue model and vector table.
module tb_wb_buffer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, hold = 1'b0;
  logic [3:0] in_addr = '0, byp_addr = '0, wp_addr;
  logic [15:0] in_data = '0, wp_data, byp_data;
  logic wp_enable, byp_hit, empty;
  logic [2:0] count;
  int n_vec = 0, n_bad = 0;
  logic live = 1'b0;
  typedef struct { logic [3:0] a; logic [15:0] d; } ent_t;
  ent_t mq[$];
  logic s_hit;
  logic [15:0] s_data;
  logic [2:0] s_count;
  typedef struct {
    logic v; logic [3:0] a; logic [15:0] d; logic h; logic [3:0] ba;
    logic [2:0] e_count; logic e_hit; logic [15:0] e_data;
  } vec_t;
  vec_t tbl[10];

  wb_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold), .wp_enable(wp_enable),
    .wp_addr(wp_addr), .wp_data(wp_data), .byp_addr(byp_addr), .byp_hit(byp_hit),
    .byp_data(byp_data), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // called at a negedge: drive, settle, compare against the model, advance the model
  task automatic cyc(input logic v, input logic [3:0] a, input logic [15:0] d,
                     input logic h, input logic [3:0] ba);
    logic mpop, mrdy, ehit;
    logic [15:0] edata;
    ent_t e;
    in_valid = v; in_addr = a; in_data = d; hold = h; byp_addr = ba;
    #1;
    mpop = mq.size() != 0 && !h;
    mrdy = live && (mq.size() < 4 || mpop);
    ehit = 1'b0; edata = '0;
    foreach (mq[i]) if (mq[i].a == ba) begin ehit = 1'b1; edata = mq[i].d; end
    chk("in_ready", 32'(in_ready), 32'(mrdy));
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("wp_enable", 32'(wp_enable), 32'(mpop));
    chk("byp_hit", 32'(byp_hit), 32'(ehit));
    chk("byp_data", 32'(byp_data), 32'(edata));
    if (wp_enable) begin
      if (mq.size() == 0) chk("write_with_empty_model", 32'(wp_enable), 32'h0);
      else begin
        e = mq.pop_front();
        chk("wp_addr", 32'(wp_addr), 32'(e.a));
        chk("wp_data", 32'(wp_data), 32'(e.d));
      end
    end else begin
      chk("wp_addr_idle", 32'(wp_addr), 32'h0);
      chk("wp_data_idle", 32'(wp_data), 32'h0);
    end
    s_hit = byp_hit; s_data = byp_data; s_count = count;
    if (mrdy && v) mq.push_back('{a, d});
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{1, 2, 16'h1111, 1, 2, 0, 0, 16'h0000};
    tbl[1] = '{1, 2, 16'h2222, 1, 2, 1, 1, 16'h1111};
    tbl[2] = '{1, 7, 16'h7777, 1, 2, 2, 1, 16'h2222};
    tbl[3] = '{0, 0, 16'h0000, 1, 2, 3, 1, 16'h2222};
    tbl[4] = '{0, 0, 16'h0000, 1, 4, 3, 0, 16'h0000};
    tbl[5] = '{0, 0, 16'h0000, 1, 7, 3, 1, 16'h7777};
    tbl[6] = '{0, 0, 16'h0000, 0, 2, 3, 1, 16'h2222};
    tbl[7] = '{0, 0, 16'h0000, 0, 2, 2, 1, 16'h2222};
    tbl[8] = '{0, 0, 16'h0000, 0, 2, 1, 0, 16'h0000};
    tbl[9] = '{0, 0, 16'h0000, 0, 7, 0, 0, 16'h0000};
    // reset
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_wp_enable", 32'(wp_enable), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_byp_hit", 32'(byp_hit), 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("release_in_ready_before_edge", 32'(in_ready), 32'h0);
    @(negedge clk);
    live = 1'b1;
    // single result, one-cycle latency
    cyc(1, 3, 16'h00AB, 0, 3);
    cyc(0, 0, 0, 0, 3);
    cyc(0, 0, 0, 0, 3);
    // fill under hold: fifth offer refused, then in-order drain with pointer wrap
    for (int i = 0; i < 5; i++) cyc(1, 4'(i + 8), 16'hA000 + 16'(i), 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    // full buffer accepts while draining
    for (int i = 0; i < 4; i++) cyc(1, 4'(i), 16'hB000 + 16'(i), 1, 1);
    cyc(1, 4'hC, 16'hC000, 0, 4'hC);
    cyc(1, 4'hD, 16'hD000, 0, 4'hC);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 4'hD);
    // bypass vectors
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].ba);
      chk($sformatf("tbl%0d_count", i), 32'(s_count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_hit", i), 32'(s_hit), 32'(tbl[i].e_hit));
      chk($sformatf("tbl%0d_data", i), 32'(s_data), 32'(tbl[i].e_data));
    end
    // asynchronous reset mid-drain
    for (int i = 0; i < 4; i++) cyc(1, 4'(i + 4), 16'hE000 + 16'(i), 1, 0);
    cyc(0, 0, 0, 0, 0);
    hold = 1'b0;
    #1 chk("pre_rst_wp_enable", 32'(wp_enable), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_wp_enable", 32'(wp_enable), 32'h0);
    chk("async_count", 32'(count), 32'h0);
    chk("async_in_ready", 32'(in_ready), 32'h0);
    mq.delete();
    live = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    live = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 4'(i + 4));
    // random traffic against the model
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom));
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
